// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq_pkg
//  Description : Opcodes, FSM state type and operand-decode helpers shared by
//                the iterative multiply/divide unit and the execute-stage ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_muldiv_seq_pkg;

   localparam logic [4:0] OPMUL    = 5'h10;
   localparam logic [4:0] OPMULH   = 5'h11;
   localparam logic [4:0] OPMULHSU = 5'h12;
   localparam logic [4:0] OPMULHU  = 5'h13;
   localparam logic [4:0] OPDIV    = 5'h14;
   localparam logic [4:0] OPDIVU   = 5'h15;
   localparam logic [4:0] OPREM    = 5'h16;
   localparam logic [4:0] OPREMU   = 5'h17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   localparam int MULDIV_WIDTH = 64;
   localparam int MULDIV_LAT   = MULDIV_WIDTH + 1;

   function automatic logic op_a_signed(input logic [4:0] op);
      return op inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM};
   endfunction

   function automatic logic op_b_signed(input logic [4:0] op);
      return op inside {OPMUL, OPMULH, OPDIV, OPREM};
   endfunction

   function automatic logic op_is_div(input logic [4:0] op);
      return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
   endfunction

   function automatic logic op_is_valid(input logic [4:0] op);
      return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU,
                        OPDIV, OPDIVU, OPREM, OPREMU};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq_if
//  Description : start/busy/valid request and result bundle of the mul/div unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_muldiv_seq_if #(
   parameter int WIDTH = 64
);
   logic             iStart;
   logic [4:0]       iControl;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             oBusy;
   logic             oValid;
   logic [WIDTH-1:0] oResult;

   modport master (output iStart, iControl, iA, iB,
                   input  oBusy, oValid, oResult);
   modport slave  (input  iStart, iControl, iA, iB,
                   output oBusy, oValid, oResult);
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One radix-2 iteration on {hi, lo}: shift-add (multiply) or
//                restoring shift-subtract (divide).
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step #(
   parameter int WIDTH = 64
) (
   input  wire logic             i_div,
   input  wire logic [WIDTH-1:0] i_hi,
   input  wire logic [WIDTH-1:0] i_lo,
   input  wire logic [WIDTH-1:0] i_opd,
   output logic      [WIDTH-1:0] o_hi,
   output logic      [WIDTH-1:0] o_lo
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   always_comb begin
      w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opd} : '0);
      w_sh   = {i_hi, i_lo[WIDTH-1]};
      w_ge   = (w_sh >= {1'b0, i_opd});
      // rem < divisor keeps a successful difference below 2^WIDTH
      w_diff = w_sh[WIDTH-1:0] - i_opd;
      if (i_div) begin
         o_hi = w_ge ? w_diff : w_sh[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], w_ge};
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end
endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Iterative RV64IM multiply/divide unit, start/busy/valid handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input wire logic          iCLK,
   input wire logic          iRST,
   alu_muldiv_seq_if.slave   bus
);
   muldiv_state_t    r_state, w_state_nxt;
   logic [CNTW-1:0]  r_cnt;
   logic [4:0]       r_op;
   logic             r_div;
   logic             r_neg;
   logic             r_rneg;
   logic [WIDTH-1:0] r_hi, r_lo, r_opd;
   logic [WIDTH-1:0] r_result;
   logic             r_valid;

   logic             w_a_sgn, w_b_sgn, w_is_div, w_ok, w_dz, w_ovf, w_fast;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic [WIDTH-1:0] w_step_hi, w_step_lo;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0] w_quo, w_rem, w_fix_res;

   // ---------------- operand decode at acceptance ----------------
   always_comb begin
      w_a_sgn  = op_a_signed(bus.iControl) & bus.iA[WIDTH-1];
      w_b_sgn  = op_b_signed(bus.iControl) & bus.iB[WIDTH-1];
      w_a_mag  = w_a_sgn ? -bus.iA : bus.iA;
      w_b_mag  = w_b_sgn ? -bus.iB : bus.iB;
      w_is_div = op_is_div(bus.iControl);
      w_ok     = op_is_valid(bus.iControl);
      w_dz     = w_is_div && (bus.iB == '0);
      w_ovf    = w_is_div && op_b_signed(bus.iControl)
                 && (bus.iA == {1'b1, {(WIDTH-1){1'b0}}})
                 && (bus.iB == '1);
      w_fast   = !w_ok || w_dz || w_ovf;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div (r_div),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .i_opd (r_opd),
      .o_hi  (w_step_hi),
      .o_lo  (w_step_lo)
   );

   // Fast-path results are preloaded with cleared sign flags, so FIX passes them through
   always_comb begin
      w_prod_s = r_neg  ? -{r_hi, r_lo} : {r_hi, r_lo};
      w_quo    = r_neg  ? -r_lo : r_lo;
      w_rem    = r_rneg ? -r_hi : r_hi;
      case (r_op)
         OPMUL:                      w_fix_res = w_prod_s[WIDTH-1:0];
         OPMULH, OPMULHSU, OPMULHU:  w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
         OPDIV, OPDIVU:              w_fix_res = w_quo;
         OPREM, OPREMU:              w_fix_res = w_rem;
         default:                    w_fix_res = '0;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge iCLK) begin
      if (iRST) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (bus.iStart) w_state_nxt = w_fast ? FIX : CALC;
         CALC: if (r_cnt == '0) w_state_nxt = FIX;
         FIX:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_div    <= 1'b0;
         r_neg    <= 1'b0;
         r_rneg   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opd    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: if (bus.iStart) begin
               r_op  <= bus.iControl;
               r_div <= w_is_div;
               r_cnt <= CNTW'(WIDTH - 1);
               r_hi  <= '0;
               r_neg <= 1'b0;
               r_rneg <= 1'b0;
               if (!w_ok) begin
                  r_lo <= '0;
               end else if (w_dz) begin
                  r_hi <= bus.iA;
                  r_lo <= '1;
               end else if (w_ovf) begin
                  r_lo <= bus.iA;
               end else if (w_is_div) begin
                  r_lo   <= w_a_mag;
                  r_opd  <= w_b_mag;
                  r_neg  <= w_a_sgn ^ w_b_sgn;
                  r_rneg <= w_a_sgn;
               end else begin
                  r_lo  <= w_b_mag;
                  r_opd <= w_a_mag;
                  r_neg <= w_a_sgn ^ w_b_sgn;
               end
            end
            CALC: begin
               r_hi  <= w_step_hi;
               r_lo  <= w_step_lo;
               r_cnt <= r_cnt - 1'b1;
            end
            FIX: begin
               r_result <= w_fix_res;
               r_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.oBusy   = (r_state != IDLE);
   assign bus.oValid  = r_valid;
   assign bus.oResult = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Directed self-checking bench for alu_muldiv_seq at WIDTH=64.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   alu_muldiv_seq_if #(.WIDTH(64)) bus ();

   alu_muldiv_seq #(.WIDTH(64)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // drives a request for one edge; returns 1 time unit after the accepting edge
   task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      bus.iStart   = 1'b1;
      bus.iControl = op;
      bus.iA       = a;
      bus.iB       = b;
      @(posedge clk);
      #1;
      bus.iStart   = 1'b0;
      bus.iA       = 64'hDEAD_BEEF_0BAD_F00D;
      bus.iB       = 64'h0123_4567_89AB_CDEF;
   endtask

   task automatic await(output logic [63:0] res, output int lat, output int busyc);
      logic got;
      got   = 1'b0;
      lat   = 0;
      busyc = bus.oBusy ? 1 : 0;
      res   = '0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.oValid) begin
            res = bus.oResult;
            got = 1'b1;
            break;
         end
         if (bus.oBusy) busyc++;
      end
      check("completion", {63'd0, got}, 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
      logic [63:0] res;
      int          lat, busyc;
      @(negedge clk);
      issue(op, a, b);
      await(res, lat, busyc);
      check(tag, res, exp);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(busyc), 64'(exp_lat));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {63'd0, bus.oValid}, 64'd0);
      check({tag, "_hold"}, bus.oResult, exp);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.oValid) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      int          lat, busyc;

      rst          = 1'b1;
      bus.iStart   = 1'b0;
      bus.iControl = '0;
      bus.iA       = '0;
      bus.iB       = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy",   {63'd0, bus.oBusy},  64'd0);
      check("rst_valid",  {63'd0, bus.oValid}, 64'd0);
      check("rst_result", bus.oResult,         64'd0);

      run_op("mul_neg",   OPMUL,    -64'sd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      run_op("mulhu",     OPMULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_op("mulh",      OPMULH,   '1, '1, 64'd0, 65);
      run_op("mulhsu",    OPMULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("div_neg",   OPDIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("rem_neg",   OPREM,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("divu",      OPDIVU,   64'd100, 64'd7, 64'd14, 65);
      run_op("remu",      OPREMU,   64'd100, 64'd7, 64'd2, 65);
      run_op("div_zero",  OPDIV,    64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("rem_zero",  OPREM,    64'h1234, 64'd0, 64'h1234, 1);
      run_op("div_ovf",   OPDIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
      run_op("rem_ovf",   OPREM,    64'h8000_0000_0000_0000, '1, 64'd0, 1);
      run_op("bad_op",    5'h03,    64'd55, 64'd66, 64'd0, 1);

      // back-to-back: new request raised in the valid cycle of the previous one
      @(negedge clk);
      issue(OPMUL, 64'd5, 64'd9);
      await(res, lat, busyc);
      check("b2b_first", res, 64'd45);
      issue(OPDIVU, 64'd1000, 64'd10);
      await(res, lat, busyc);
      check("b2b_second", res, 64'd100);
      check("b2b_lat", 64'(lat), 64'd65);

      // start pulses while busy must be ignored
      @(negedge clk);
      issue(OPDIVU, 64'd100, 64'd7);
      repeat (5) @(negedge clk);
      bus.iStart = 1'b1; bus.iControl = OPMUL; bus.iA = 64'd6; bus.iB = 64'd7;
      repeat (3) @(negedge clk);
      bus.iStart = 1'b0;
      await(res, lat, busyc);
      check("busy_ignore", res, 64'd14);
      watch_no_valid("busy_ignore_extra", 70);

      // reset in the middle of a divide
      @(negedge clk);
      issue(OPDIV, -64'sd7, 64'd2);
      repeat (29) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy",   {63'd0, bus.oBusy},  64'd0);
      check("midrst_valid",  {63'd0, bus.oValid}, 64'd0);
      check("midrst_result", bus.oResult,         64'd0);
      watch_no_valid("midrst_novalid", 70);

      // reset and start on the same edge: request dropped
      @(negedge clk);
      rst = 1'b1;
      bus.iStart = 1'b1; bus.iControl = OPMUL; bus.iA = 64'd3; bus.iB = 64'd3;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.iStart = 1'b0;
      check("rst_start_busy", {63'd0, bus.oBusy}, 64'd0);
      watch_no_valid("rst_start_novalid", 70);

      run_op("mul_after_rst", OPMUL, 64'd6, 64'd7, 64'd42, 65);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
